// File: rtl/key_load_seq.sv
// key_load_seq
//   Front-end for the multi-operand ALU datapath. Three raw push buttons
//   (load A, load B, latch F) are polarity-corrected, synchronized and
//   debounced. Each debounced press then becomes a single-cycle load strobe,
//   gated by a small sequencing FSM that rejects out-of-order loads.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   key_in     raw buttons [0]=A, [1]=B, [2]=F (asynchronous, bouncing)
//   ld_a       one-cycle strobe: load operand A
//   ld_b       one-cycle strobe: load operand B
//   ld_f       one-cycle strobe: latch ALU result and flags
//   seq_err    one-cycle strobe: press rejected (out of order / lost to priority)
//   stage      FSM state for LEDs (0=EMPTY 1=HAVE_A 2=HAVE_AB 3=DONE)
//   key_state  debounced pressed level per key, active-high
module key_load_seq #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit KEY_ACTIVE_LOW  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] key_in,
    output logic       ld_a,
    output logic       ld_b,
    output logic       ld_f,
    output logic       seq_err,
    output logic [1:0] stage,
    output logic [2:0] key_state
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        HAVE_A  = 2'd1,
        HAVE_AB = 2'd2,
        DONE    = 2'd3
    } state_t;

    logic [2:0] key_p0;
    logic [2:0] sync_p1;
    logic [2:0] sync_p2;
    logic [2:0] stable_p3;
    logic [2:0] stable_p4;
    logic [2:0] press_vld_p4;

    state_t state_q, state_d;
    logic   ld_a_d, ld_b_d, ld_f_d, seq_err_d;

    // Stage 0..2: polarity-corrected input register, then the two-flop
    // synchronizer. Reset value 0 means "released" for every key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_p0  <= 3'b000;
            sync_p1 <= 3'b000;
            sync_p2 <= 3'b000;
        end else begin
            key_p0  <= key_in ^ {3{KEY_ACTIVE_LOW}};
            sync_p1 <= key_p0;
            sync_p2 <= sync_p1;
        end
    end

    // Stage 3: per-key debouncer. A new level is accepted only after it has
    // differed from the stable level for DEBOUNCE_CYCLES consecutive cycles;
    // any cycle back at the stable level restarts the count.
    for (genvar i = 0; i < 3; i++) begin : g_deb
        logic [CNT_W-1:0] cnt;
        logic             stable;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= '0;
                stable <= 1'b0;
            end else if (sync_p2[i] == stable) begin
                cnt    <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt    <= '0;
                stable <= sync_p2[i];
            end else begin
                cnt    <= cnt + CNT_W'(1);
            end
        end

        assign stable_p3[i] = stable;
    end

    // Stage 4: press edge detection (release makes no event).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_p4 <= 3'b000;
        end else begin
            stable_p4 <= stable_p3;
        end
    end

    assign press_vld_p4 = stable_p3 & ~stable_p4;

    // Sequencing FSM: one event per cycle, priority A > B > F. A dropped
    // lower-priority press is reported through seq_err alongside the strobe.
    always_comb begin
        state_d   = state_q;
        ld_a_d    = 1'b0;
        ld_b_d    = 1'b0;
        ld_f_d    = 1'b0;
        seq_err_d = 1'b0;
        if (press_vld_p4[0]) begin
            // Reloading A invalidates any previously loaded B.
            ld_a_d    = 1'b1;
            state_d   = HAVE_A;
            seq_err_d = press_vld_p4[1] | press_vld_p4[2];
        end else if (press_vld_p4[1]) begin
            seq_err_d = press_vld_p4[2];
            if (state_q == EMPTY) begin
                seq_err_d = 1'b1;
            end else begin
                ld_b_d  = 1'b1;
                state_d = HAVE_AB;
            end
        end else if (press_vld_p4[2]) begin
            if (state_q == HAVE_AB || state_q == DONE) begin
                ld_f_d  = 1'b1;
                state_d = DONE;
            end else begin
                seq_err_d = 1'b1;
            end
        end
    end

    // Stage 5: registered strobes and state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ld_a    <= 1'b0;
            ld_b    <= 1'b0;
            ld_f    <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            state_q <= state_d;
            ld_a    <= ld_a_d;
            ld_b    <= ld_b_d;
            ld_f    <= ld_f_d;
            seq_err <= seq_err_d;
        end
    end

    assign stage     = state_q;
    assign key_state = stable_p3;

endmodule

// File: tb/tb_key_load_seq.sv
// Testbench for key_load_seq with DEBOUNCE_CYCLES=4. Two instances are run
// in lockstep: one with active-high keys and one with active-low keys driven
// with the inverted button vector; both must match the same reference model.
module tb_key_load_seq;

    localparam int D = 4;

    logic       clk;
    logic       rst_n;
    logic [2:0] key;
    logic [2:0] key_n;

    logic       ld_a0, ld_b0, ld_f0, err0;
    logic [1:0] stage0;
    logic [2:0] kst0;
    logic       ld_a1, ld_b1, ld_f1, err1;
    logic [1:0] stage1;
    logic [2:0] kst1;

    assign key_n = ~key;

    key_load_seq #(.DEBOUNCE_CYCLES(D), .KEY_ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .key_in(key),
        .ld_a(ld_a0), .ld_b(ld_b0), .ld_f(ld_f0), .seq_err(err0),
        .stage(stage0), .key_state(kst0)
    );

    key_load_seq #(.DEBOUNCE_CYCLES(D), .KEY_ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .key_in(key_n),
        .ld_a(ld_a1), .ld_b(ld_b1), .ld_f(ld_f1), .seq_err(err1),
        .stage(stage1), .key_state(kst1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // hist[j] is the (active-high) button vector seen before the edge j
    // cycles ago. After the 3-cycle input pipeline, a key's debounced level
    // flips once the last D pipelined samples all disagree with it.
    logic [2:0] hist [D+3];
    logic [2:0] m_stable, m_rise;
    int         m_stage;
    logic       m_a, m_b, m_f, m_err;

    task automatic model_reset();
        for (int j = 0; j < D + 3; j++) hist[j] = 3'b000;
        m_stable = 3'b000;
        m_rise   = 3'b000;
        m_stage  = 0;
        {m_a, m_b, m_f, m_err} = 4'b0000;
    endtask

    task automatic model_step();
        logic [2:0] nxt;
        logic       all_diff;
        if (!rst_n) begin
            model_reset();
            return;
        end
        {m_a, m_b, m_f, m_err} = 4'b0000;
        if (m_rise[0]) begin
            m_a = 1'b1;
            m_stage = 1;
            if (m_rise[1] || m_rise[2]) m_err = 1'b1;
        end else if (m_rise[1]) begin
            if (m_rise[2]) m_err = 1'b1;
            if (m_stage == 0) m_err = 1'b1;
            else begin
                m_b = 1'b1;
                m_stage = 2;
            end
        end else if (m_rise[2]) begin
            if (m_stage >= 2) begin
                m_f = 1'b1;
                m_stage = 3;
            end else m_err = 1'b1;
        end
        for (int j = D + 2; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = key;
        nxt = m_stable;
        for (int b = 0; b < 3; b++) begin
            all_diff = 1'b1;
            for (int j = 3; j < D + 3; j++)
                if (hist[j][b] == m_stable[b]) all_diff = 1'b0;
            if (all_diff) nxt[b] = ~m_stable[b];
        end
        m_rise   = nxt & ~m_stable;
        m_stable = nxt;
    endtask

    // ---------------- cycle driver and observers ----------------
    int cnt_a, cnt_b, cnt_f, cnt_err, first_a, first_b, a_with_err, cyc_idx;

    task automatic clear_counts();
        cnt_a = 0; cnt_b = 0; cnt_f = 0; cnt_err = 0;
        first_a = -1; first_b = -1; a_with_err = 0; cyc_idx = 0;
    endtask

    task automatic run(input int n);
        logic [15:0] exp_v;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            exp_v = {7'd0, m_a, m_b, m_f, m_err, m_stage[1:0], m_stable};
            chk("dut0_out", {7'd0, ld_a0, ld_b0, ld_f0, err0, stage0, kst0}, exp_v);
            chk("dut1_out", {7'd0, ld_a1, ld_b1, ld_f1, err1, stage1, kst1}, exp_v);
            if (ld_a0) begin
                cnt_a++;
                if (first_a < 0) first_a = cyc_idx;
                if (err0) a_with_err++;
            end
            if (ld_b0) begin
                cnt_b++;
                if (first_b < 0) first_b = cyc_idx;
            end
            if (ld_f0) cnt_f++;
            if (err0)  cnt_err++;
            cyc_idx++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        run(3);
        chk("reset_state", {7'd0, ld_a0, ld_b0, ld_f0, err0, stage0, kst0}, 16'd0);
        rst_n = 1'b1;
    endtask

    task automatic press(input logic [2:0] m);
        clear_counts();
        key = m;
        run(12);
        key = 3'b000;
        run(10);
    endtask

    initial begin
        key   = 3'b000;
        rst_n = 1'b0;
        model_reset();
        clear_counts();
        @(negedge clk);
        do_reset();

        // Clean press of A held down: exactly one strobe, 7 edges in.
        clear_counts();
        key = 3'b001;
        run(20);
        chk("clean_lat_a", 16'(first_a), 16'd7);
        chk("clean_cnt_a", 16'(cnt_a), 16'd1);
        chk("clean_stage", 16'(stage0), 16'd1);
        chk("clean_kstate", 16'(kst0), 16'd1);
        key = 3'b000;
        run(10);
        chk("release_kstate", 16'(kst0), 16'd0);

        // Bouncing B: 1,0,1,0 then held 1.
        key = 3'b010; run(1);
        key = 3'b000; run(1);
        key = 3'b010; run(1);
        key = 3'b000; run(1);
        clear_counts();
        key = 3'b010;
        run(20);
        chk("bounce_lat_b", 16'(first_b), 16'd7);
        chk("bounce_cnt_b", 16'(cnt_b), 16'd1);
        chk("bounce_stage", 16'(stage0), 16'd2);
        key = 3'b000;
        run(10);

        // Out of order from reset: B then F are both rejected.
        do_reset();
        press(3'b010);
        chk("ooo_b_err", 16'(cnt_err), 16'd1);
        chk("ooo_b_ld", 16'(cnt_b), 16'd0);
        chk("ooo_b_stage", 16'(stage0), 16'd0);
        press(3'b100);
        chk("ooo_f_err", 16'(cnt_err), 16'd1);
        chk("ooo_f_ld", 16'(cnt_f), 16'd0);
        chk("ooo_f_stage", 16'(stage0), 16'd0);

        // Full sequence A, B, F, F, then B again.
        press(3'b001); chk("seq_a", 16'({cnt_a[3:0], 2'd0, stage0}), 16'h0011);
        press(3'b010); chk("seq_b", 16'({cnt_b[3:0], 2'd0, stage0}), 16'h0012);
        press(3'b100); chk("seq_f1", 16'({cnt_f[3:0], 2'd0, stage0}), 16'h0013);
        press(3'b100); chk("seq_f2", 16'({cnt_f[3:0], 2'd0, stage0}), 16'h0013);
        press(3'b010); chk("seq_b2", 16'({cnt_b[3:0], 2'd0, stage0}), 16'h0012);

        // A and F settle together from HAVE_AB: A wins, F reported as error.
        press(3'b101);
        chk("simul_a_err", 16'(a_with_err), 16'd1);
        chk("simul_f", 16'(cnt_f), 16'd0);
        chk("simul_stage", 16'(stage0), 16'd1);

        // Reset in the middle of debouncing a held A.
        clear_counts();
        key = 3'b001;
        run(4);
        rst_n = 1'b0;
        model_reset();
        chk("mid_rst_no_a", 16'(cnt_a), 16'd0);
        run(2);
        rst_n = 1'b1;
        clear_counts();
        run(20);
        chk("mid_rst_lat_a", 16'(first_a), 16'd7);
        chk("mid_rst_cnt_a", 16'(cnt_a), 16'd1);
        key = 3'b000;
        run(10);

        // Randomized button activity with occasional resets.
        for (int s = 0; s < 80; s++) begin
            if ($urandom_range(0, 24) == 0) begin
                rst_n = 1'b0;
                model_reset();
                run(2);
                rst_n = 1'b1;
            end
            key = 3'($urandom_range(0, 7));
            run($urandom_range(1, 14));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
